// File: rtl/bpred_gshare_dual_pkg.sv
// Shared constants for the dual-slot gshare predictor:
// 2-bit counter encodings and the PHT reset value.
package bpred_gshare_dual_pkg;

    localparam logic [1:0] CTR_SNT = 2'd0;
    localparam logic [1:0] CTR_WNT = 2'd1;
    localparam logic [1:0] CTR_WT  = 2'd2;
    localparam logic [1:0] CTR_ST  = 2'd3;

    localparam logic [1:0] PHT_RST = CTR_WNT;

    function automatic logic ctr_taken(input logic [1:0] c);
        return c[1];
    endfunction

endpackage

// File: rtl/bpred_gshare_dual_if.sv
// Fetch lookup, commit update and return-stack signals of the
// dual-slot gshare predictor, bundled for port connection.
interface bpred_gshare_dual_if #(
    parameter int PC_W  = 32,
    parameter int GHR_W = 8
);
    logic             i_inst_vld_1;
    logic             i_inst_vld_2;
    logic [PC_W-1:0]  i_pc_1;
    logic [PC_W-1:0]  i_pc_2;
    logic             o_pred_jmp;
    logic             o_pred_slot;
    logic [PC_W-1:0]  o_pred_tgt;
    logic [GHR_W-1:0] o_ghr;

    logic             i_com_br;
    logic [PC_W-1:0]  i_com_pc;
    logic [GHR_W-1:0] i_com_ghr;
    logic [PC_W-1:0]  i_com_jmpaddr;
    logic             i_com_jmpcond;
    logic             i_com_mispred;

    logic             i_ras_push;
    logic [PC_W-1:0]  i_ras_push_addr;
    logic             i_ras_pop;
    logic [PC_W-1:0]  o_ras_top;
    logic             o_ras_empty;

    modport master (
        output i_inst_vld_1, i_inst_vld_2, i_pc_1, i_pc_2,
        output i_com_br, i_com_pc, i_com_ghr,
        output i_com_jmpaddr, i_com_jmpcond, i_com_mispred,
        output i_ras_push, i_ras_push_addr, i_ras_pop,
        input  o_pred_jmp, o_pred_slot, o_pred_tgt, o_ghr,
        input  o_ras_top, o_ras_empty
    );

    modport slave (
        input  i_inst_vld_1, i_inst_vld_2, i_pc_1, i_pc_2,
        input  i_com_br, i_com_pc, i_com_ghr,
        input  i_com_jmpaddr, i_com_jmpcond, i_com_mispred,
        input  i_ras_push, i_ras_push_addr, i_ras_pop,
        output o_pred_jmp, o_pred_slot, o_pred_tgt, o_ghr,
        output o_ras_top, o_ras_empty
    );

endinterface

// File: rtl/bpred_sat_ctr2.sv
// Next-state function of a 2-bit saturating branch counter.
module bpred_sat_ctr2
    import bpred_gshare_dual_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_nxt
);

    always_comb begin
        ctr_nxt = ctr;
        unique case (1'b1)
            taken && (ctr != CTR_ST):   ctr_nxt = ctr + 2'd1;
            !taken && (ctr != CTR_SNT): ctr_nxt = ctr - 2'd1;
            default: ;
        endcase
    end

endmodule

// File: rtl/bpred_gshare_dual.sv
// Two-slot gshare predictor with direct-mapped BTB; the optional
// return stack is built only when BPRED_RAS_EN is defined.
module bpred_gshare_dual
    import bpred_gshare_dual_pkg::*;
#(
    parameter int PC_W      = 32,
    parameter int GHR_W     = 8,
    parameter int BTB_ENT   = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    bpred_gshare_dual_if.slave  bus
);

    localparam int BI_W  = $clog2(BTB_ENT);
    localparam int TAG_W = PC_W - 2 - BI_W;
    localparam int PHT_N = 1 << GHR_W;

    logic              btb_vld [BTB_ENT];
    logic [TAG_W-1:0]  btb_tag [BTB_ENT];
    logic [PC_W-1:0]   btb_tgt [BTB_ENT];
    logic [1:0]        pht     [PHT_N];
    logic [GHR_W-1:0]  ghr;
    logic [GHR_W-1:0]  ghr_spec;

    logic [BI_W-1:0]   bi1, bi2, cbi;
    logic [GHR_W-1:0]  pi1, pi2, cpi;
    logic              hit1, hit2, tk1, tk2;
    logic [1:0]        ctr_nxt;

    assign bi1  = bus.i_pc_1[2 +: BI_W];
    assign bi2  = bus.i_pc_2[2 +: BI_W];
    assign pi1  = bus.i_pc_1[2 +: GHR_W] ^ ghr;
    assign pi2  = bus.i_pc_2[2 +: GHR_W] ^ ghr;

    assign hit1 = bus.i_inst_vld_1 && btb_vld[bi1]
               && (btb_tag[bi1] == bus.i_pc_1[PC_W-1 -: TAG_W]);
    assign hit2 = bus.i_inst_vld_2 && btb_vld[bi2]
               && (btb_tag[bi2] == bus.i_pc_2[PC_W-1 -: TAG_W]);
    assign tk1  = hit1 && ctr_taken(pht[pi1]);
    assign tk2  = hit2 && ctr_taken(pht[pi2]);

    assign bus.o_pred_jmp  = tk1 || tk2;
    assign bus.o_pred_slot = rst_n && !tk1;
    assign bus.o_pred_tgt  = tk1 ? btb_tgt[bi1]
                           : tk2 ? btb_tgt[bi2] : '0;
    assign bus.o_ghr       = ghr;

    // History stops collecting at the first predicted-taken slot
    always_comb begin
        ghr_spec = ghr;
        unique case (1'b1)
            tk1:                  ghr_spec = {ghr[GHR_W-2:0], 1'b1};
            hit1 && !tk1 && hit2: ghr_spec = {ghr[GHR_W-3:0], 1'b0, tk2};
            hit1 && !tk1 && !hit2: ghr_spec = {ghr[GHR_W-2:0], 1'b0};
            !hit1 && hit2:        ghr_spec = {ghr[GHR_W-2:0], tk2};
            default: ;
        endcase
    end

    assign cbi = bus.i_com_pc[2 +: BI_W];
    assign cpi = bus.i_com_pc[2 +: GHR_W] ^ bus.i_com_ghr;

    bpred_sat_ctr2 u_ctr (
        .ctr     (pht[cpi]),
        .taken   (bus.i_com_jmpcond),
        .ctr_nxt (ctr_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr <= '0;
            for (int i = 0; i < PHT_N; i++) pht[i] <= PHT_RST;
            for (int i = 0; i < BTB_ENT; i++) btb_vld[i] <= 1'b0;
        end else begin
            if (bus.i_com_br && bus.i_com_mispred)
                ghr <= {bus.i_com_ghr[GHR_W-2:0], bus.i_com_jmpcond};
            else
                ghr <= ghr_spec;
            if (bus.i_com_br)
                pht[cpi] <= ctr_nxt;
            if (bus.i_com_br && bus.i_com_jmpcond)
                btb_vld[cbi] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.i_com_br && bus.i_com_jmpcond) begin
            btb_tag[cbi] <= bus.i_com_pc[PC_W-1 -: TAG_W];
            btb_tgt[cbi] <= bus.i_com_jmpaddr;
        end
    end

    logic unused;
    assign unused = ^{bus.i_pc_1[1:0], bus.i_pc_2[1:0], bus.i_com_pc[1:0]};

`ifdef BPRED_RAS_EN
    localparam int RP_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int RC_W = $clog2(RAS_DEPTH + 1);

    logic [PC_W-1:0] ras [RAS_DEPTH];
    logic [RP_W-1:0] rp, rp_inc, rp_dec;
    logic [RC_W-1:0] rcnt;
    logic            ras_empty;

    assign ras_empty = (rcnt == '0);
    assign rp_inc = (rp == RP_W'(RAS_DEPTH - 1)) ? '0 : rp + RP_W'(1);
    assign rp_dec = (rp == '0) ? RP_W'(RAS_DEPTH - 1) : rp - RP_W'(1);

    // Pointer always marks the top; a full push wraps onto the oldest slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rp   <= '0;
            rcnt <= '0;
        end else begin
            unique case (1'b1)
                bus.i_ras_push && bus.i_ras_pop: ;
                bus.i_ras_push && !bus.i_ras_pop: begin
                    rp <= rp_inc;
                    if (rcnt != RC_W'(RAS_DEPTH)) rcnt <= rcnt + RC_W'(1);
                end
                bus.i_ras_pop && !bus.i_ras_push && !ras_empty: begin
                    rp   <= rp_dec;
                    rcnt <= rcnt - RC_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (bus.i_ras_push)
            ras[bus.i_ras_pop ? rp : rp_inc] <= bus.i_ras_push_addr;
    end

    assign bus.o_ras_top   = ras_empty ? '0 : ras[rp];
    assign bus.o_ras_empty = ras_empty;
`else
    assign bus.o_ras_top   = '0;
    assign bus.o_ras_empty = 1'b1;

    logic unused_ras;
    assign unused_ras = ^{bus.i_ras_push, bus.i_ras_pop, bus.i_ras_push_addr};
`endif

endmodule

// File: tb/tb_bpred_gshare_dual.sv
// Bench for bpred_gshare_dual: directed scenarios plus random
// traffic against a table-level reference model.
module tb_bpred_gshare_dual;

    localparam int PC_W      = 32;
    localparam int GHR_W     = 8;
    localparam int BTB_ENT   = 16;
    localparam int RAS_DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    bpred_gshare_dual_if #(.PC_W(PC_W), .GHR_W(GHR_W)) bus ();

    bpred_gshare_dual #(
        .PC_W(PC_W), .GHR_W(GHR_W),
        .BTB_ENT(BTB_ENT), .RAS_DEPTH(RAS_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int        m_ctr [256];
    bit        m_vld [BTB_ENT];
    bit [31:0] m_pc  [BTB_ENT];
    bit [31:0] m_tgt [BTB_ENT];
    bit [7:0]  m_ghr;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void m_reset();
        foreach (m_ctr[i]) m_ctr[i] = 1;
        foreach (m_vld[i]) m_vld[i] = 1'b0;
        m_ghr = '0;
    endfunction

    function automatic bit m_hit(bit v, bit [31:0] pc);
        int e = int'((pc >> 2) % BTB_ENT);
        return v && m_vld[e] && ((m_pc[e] >> 6) == (pc >> 6));
    endfunction

    function automatic bit m_taken(bit v, bit [31:0] pc);
        int k = int'(((pc >> 2) % 256) ^ {24'd0, m_ghr});
        return m_hit(v, pc) && (m_ctr[k] >= 2);
    endfunction

    function automatic bit [31:0] m_target(bit [31:0] pc);
        return m_tgt[int'((pc >> 2) % BTB_ENT)];
    endfunction

    // Effect of one clock edge on the model, from the inputs now applied
    function automatic void m_step();
        bit [31:0] pcs [2];
        bit        vs  [2];
        bit [7:0]  ng;
        int        k, c, e;
        pcs[0] = bus.i_pc_1; pcs[1] = bus.i_pc_2;
        vs[0]  = bus.i_inst_vld_1; vs[1] = bus.i_inst_vld_2;
        ng = m_ghr;
        for (int s = 0; s < 2; s++) begin
            if (m_hit(vs[s], pcs[s])) begin
                ng = {ng[6:0], m_taken(vs[s], pcs[s])};
                if (m_taken(vs[s], pcs[s])) break;
            end
        end
        if (bus.i_com_br) begin
            k = int'(((bus.i_com_pc >> 2) % 256) ^ {24'd0, bus.i_com_ghr});
            c = m_ctr[k] + (bus.i_com_jmpcond ? 1 : -1);
            m_ctr[k] = (c > 3) ? 3 : (c < 0) ? 0 : c;
            if (bus.i_com_jmpcond) begin
                e = int'((bus.i_com_pc >> 2) % BTB_ENT);
                m_vld[e] = 1'b1;
                m_pc[e]  = bus.i_com_pc;
                m_tgt[e] = bus.i_com_jmpaddr;
            end
            if (bus.i_com_mispred)
                ng = {bus.i_com_ghr[6:0], bus.i_com_jmpcond};
        end
        m_ghr = ng;
    endfunction

    task automatic idle();
        bus.i_inst_vld_1 = 0; bus.i_inst_vld_2 = 0;
        bus.i_pc_1 = '0; bus.i_pc_2 = '0;
        bus.i_com_br = 0; bus.i_com_pc = '0; bus.i_com_ghr = '0;
        bus.i_com_jmpaddr = '0; bus.i_com_jmpcond = 0;
        bus.i_com_mispred = 0;
        bus.i_ras_push = 0; bus.i_ras_push_addr = '0; bus.i_ras_pop = 0;
    endtask

    task automatic tick();
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        m_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic commit(bit [31:0] pc, bit [7:0] g, bit t,
                          bit [31:0] a, bit mp);
        bus.i_com_br = 1; bus.i_com_pc = pc; bus.i_com_ghr = g;
        bus.i_com_jmpcond = t; bus.i_com_jmpaddr = a;
        bus.i_com_mispred = mp;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        #1 rst_n = 1'b0;
        m_reset();
        #2;
        n_cmp++; if (bus.o_pred_jmp !== 1'b0) begin n_bad++;
            $display("FAIL rst_jmp: got %0h want 0", bus.o_pred_jmp); end
        n_cmp++; if (bus.o_pred_slot !== 1'b0) begin n_bad++;
            $display("FAIL rst_slot: got %0h want 0", bus.o_pred_slot); end
        n_cmp++; if (bus.o_pred_tgt !== 32'h0) begin n_bad++;
            $display("FAIL rst_tgt: got %0h want 0", bus.o_pred_tgt); end
        n_cmp++; if (bus.o_ghr !== 8'h0) begin n_bad++;
            $display("FAIL rst_ghr: got %0h want 0", bus.o_ghr); end
        n_cmp++; if (bus.o_ras_top !== 32'h0) begin n_bad++;
            $display("FAIL rst_ras_top: got %0h want 0", bus.o_ras_top); end
        n_cmp++; if (bus.o_ras_empty !== 1'b1) begin n_bad++;
            $display("FAIL rst_ras_empty: got %0h want 1", bus.o_ras_empty); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.i_inst_vld_1 = 1; bus.i_pc_1 = 32'h100;
        @(negedge clk);
        n_cmp++; if (bus.o_pred_jmp !== 1'b0) begin n_bad++;
            $display("FAIL cold_jmp: got %0h want 0", bus.o_pred_jmp); end
        n_cmp++; if (bus.o_ghr !== 8'h0) begin n_bad++;
            $display("FAIL cold_ghr: got %0h want 0", bus.o_ghr); end
        n_cmp++; if (bus.o_ras_empty !== 1'b1) begin n_bad++;
            $display("FAIL cold_ras_empty: got %0h want 1", bus.o_ras_empty); end
        tick();
    endtask

    task automatic test_train();
        do_reset();
        commit(32'h100, 8'h00, 1, 32'h200, 0);
        commit(32'h100, 8'h00, 1, 32'h200, 0);
        bus.i_inst_vld_1 = 1; bus.i_pc_1 = 32'h100;
        @(negedge clk);
        n_cmp++; if (bus.o_pred_jmp !== 1'b1) begin n_bad++;
            $display("FAIL train_jmp: got %0h want 1", bus.o_pred_jmp); end
        n_cmp++; if (bus.o_pred_slot !== 1'b0) begin n_bad++;
            $display("FAIL train_slot: got %0h want 0", bus.o_pred_slot); end
        n_cmp++; if (bus.o_pred_tgt !== 32'h200) begin n_bad++;
            $display("FAIL train_tgt: got %0h want 200", bus.o_pred_tgt); end
        tick();
        idle();
        @(negedge clk);
        n_cmp++; if (bus.o_ghr !== 8'h01) begin n_bad++;
            $display("FAIL train_ghr: got %0h want 01", bus.o_ghr); end
    endtask

    task automatic test_slot2();
        do_reset();
        commit(32'h104, 8'h00, 1, 32'h240, 0);
        commit(32'h104, 8'h00, 1, 32'h240, 0);
        bus.i_inst_vld_1 = 1; bus.i_pc_1 = 32'h100;
        bus.i_inst_vld_2 = 1; bus.i_pc_2 = 32'h104;
        @(negedge clk);
        n_cmp++; if (bus.o_pred_jmp !== 1'b1) begin n_bad++;
            $display("FAIL slot2_jmp: got %0h want 1", bus.o_pred_jmp); end
        n_cmp++; if (bus.o_pred_slot !== 1'b1) begin n_bad++;
            $display("FAIL slot2_slot: got %0h want 1", bus.o_pred_slot); end
        n_cmp++; if (bus.o_pred_tgt !== 32'h240) begin n_bad++;
            $display("FAIL slot2_tgt: got %0h want 240", bus.o_pred_tgt); end
        tick();
        idle();
        @(negedge clk);
        n_cmp++; if (bus.o_ghr !== 8'h01) begin n_bad++;
            $display("FAIL slot2_ghr: got %0h want 01", bus.o_ghr); end
    endtask

    task automatic test_mispred();
        commit(32'h800, 8'h52, 1, 32'h900, 1);
        @(negedge clk);
        n_cmp++; if (bus.o_ghr !== 8'hA5) begin n_bad++;
            $display("FAIL misp_pre_ghr: got %0h want a5", bus.o_ghr); end
        bus.i_inst_vld_1 = 1; bus.i_pc_1 = 32'h104;
        commit(32'h808, 8'h3C, 1, 32'h980, 1);
        @(negedge clk);
        n_cmp++; if (bus.o_ghr !== 8'h79) begin n_bad++;
            $display("FAIL misp_ghr: got %0h want 79", bus.o_ghr); end
    endtask

    task automatic test_saturate();
        do_reset();
        repeat (4) commit(32'h100, 8'h00, 1, 32'h200, 0);
        commit(32'h100, 8'h00, 0, 32'h0, 0);
        bus.i_inst_vld_1 = 1; bus.i_pc_1 = 32'h100;
        @(negedge clk);
        n_cmp++; if (bus.o_pred_jmp !== 1'b1) begin n_bad++;
            $display("FAIL sat_hi_jmp: got %0h want 1", bus.o_pred_jmp); end
        tick();
        idle();
        commit(32'h800, 8'h00, 0, 32'h0, 1);
        repeat (3) commit(32'h100, 8'h00, 0, 32'h0, 0);
        commit(32'h100, 8'h00, 1, 32'h200, 0);
        bus.i_inst_vld_1 = 1; bus.i_pc_1 = 32'h100;
        @(negedge clk);
        n_cmp++; if (bus.o_pred_jmp !== 1'b0) begin n_bad++;
            $display("FAIL sat_lo_jmp: got %0h want 0", bus.o_pred_jmp); end
        n_cmp++; if (bus.o_pred_tgt !== 32'h0) begin n_bad++;
            $display("FAIL sat_lo_tgt: got %0h want 0", bus.o_pred_tgt); end
        tick();
        idle();
    endtask

    function automatic bit [31:0] pick_pc();
        bit [31:0] base = $urandom_range(0, 2) == 0 ? 32'h1100 : 32'h100;
        return base + 32'(4 * $urandom_range(0, 23));
    endfunction

    task automatic test_random();
        bit        e_jmp, t1, t2;
        bit [31:0] e_tgt;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            idle();
            bus.i_inst_vld_1 = ($urandom_range(0, 3) != 0);
            bus.i_inst_vld_2 = ($urandom_range(0, 3) != 0);
            bus.i_pc_1 = pick_pc();
            bus.i_pc_2 = $urandom_range(0, 1) ? bus.i_pc_1 + 4 : pick_pc();
            if ($urandom_range(0, 1) == 1) begin
                bus.i_com_br = 1;
                bus.i_com_pc = pick_pc();
                bus.i_com_ghr = $urandom_range(0, 1) ? m_ghr : 8'($urandom);
                bus.i_com_jmpcond = 1'($urandom);
                bus.i_com_jmpaddr = $urandom & 32'hFFFF_FFFC;
                bus.i_com_mispred = ($urandom_range(0, 6) == 0);
            end
            @(negedge clk);
            t1 = m_taken(bus.i_inst_vld_1, bus.i_pc_1);
            t2 = m_taken(bus.i_inst_vld_2, bus.i_pc_2);
            e_jmp = t1 || t2;
            e_tgt = t1 ? m_target(bus.i_pc_1) : t2 ? m_target(bus.i_pc_2) : 0;
            n_cmp++; if (bus.o_pred_jmp !== e_jmp) begin n_bad++;
                $display("FAIL rnd_jmp[%0d]: got %0h want %0h", n, bus.o_pred_jmp, e_jmp); end
            n_cmp++; if (bus.o_pred_tgt !== e_tgt) begin n_bad++;
                $display("FAIL rnd_tgt[%0d]: got %0h want %0h", n, bus.o_pred_tgt, e_tgt); end
            n_cmp++; if (bus.o_ghr !== m_ghr) begin n_bad++;
                $display("FAIL rnd_ghr[%0d]: got %0h want %0h", n, bus.o_ghr, m_ghr); end
            if (e_jmp) begin
                n_cmp++; if (bus.o_pred_slot !== !t1) begin n_bad++;
                    $display("FAIL rnd_slot[%0d]: got %0h want %0h", n, bus.o_pred_slot, !t1); end
            end
            tick();
        end
        idle();
    endtask

`ifdef BPRED_RAS_EN
    task automatic test_ras();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            bus.i_ras_push = 1; bus.i_ras_push_addr = 32'(i * 16);
            tick();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if (bus.o_ras_top !== 32'(80 - 16 * i)) begin n_bad++;
                $display("FAIL ras_top[%0d]: got %0h want %0h", i, bus.o_ras_top, 80 - 16 * i); end
            n_cmp++; if (bus.o_ras_empty !== 1'b0) begin n_bad++;
                $display("FAIL ras_full[%0d]: got %0h want 0", i, bus.o_ras_empty); end
            bus.i_ras_pop = 1;
            tick();
            bus.i_ras_pop = 0;
        end
        @(negedge clk);
        n_cmp++; if (bus.o_ras_empty !== 1'b1) begin n_bad++;
            $display("FAIL ras_drained: got %0h want 1", bus.o_ras_empty); end
        bus.i_ras_pop = 1;
        tick();
        idle();
        @(negedge clk);
        n_cmp++; if (bus.o_ras_empty !== 1'b1) begin n_bad++;
            $display("FAIL ras_underflow: got %0h want 1", bus.o_ras_empty); end
        bus.i_ras_push = 1; bus.i_ras_push_addr = 32'h77;
        tick();
        bus.i_ras_pop = 1; bus.i_ras_push_addr = 32'h88;
        tick();
        idle();
        @(negedge clk);
        n_cmp++; if (bus.o_ras_top !== 32'h88) begin n_bad++;
            $display("FAIL ras_replace: got %0h want 88", bus.o_ras_top); end
    endtask
`else
    task automatic test_ras();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            bus.i_ras_push = 1'($urandom);
            bus.i_ras_pop = 1'($urandom);
            bus.i_ras_push_addr = $urandom;
            @(negedge clk);
            n_cmp++; if (bus.o_ras_top !== 32'h0) begin n_bad++;
                $display("FAIL ras_off_top[%0d]: got %0h want 0", i, bus.o_ras_top); end
            n_cmp++; if (bus.o_ras_empty !== 1'b1) begin n_bad++;
                $display("FAIL ras_off_empty[%0d]: got %0h want 1", i, bus.o_ras_empty); end
            tick();
        end
        idle();
    endtask
`endif

    initial begin
        test_reset();
        test_train();
        test_slot2();
        test_mispred();
        test_saturate();
        test_random();
        test_ras();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bpred_gshare_dual.md
BPRED_GSHARE_DUAL -- requirements
Module: bpred_gshare_dual

Interface
REQ-001 SHALL have parameter PC_W, default 32: PC/target width.
REQ-002 SHALL have parameter GHR_W, default 8: GHR width; the PHT has 2^GHR_W 2-bit counters.
REQ-003 SHALL have parameter BTB_ENT, default 16, power of 2: direct-mapped BTB entries.
REQ-004 SHALL have parameter RAS_DEPTH, default 4: return stack entries, used only with BPRED_RAS_EN.
REQ-005 SHALL have ports: clk in 1 clock; rst_n in 1 async active-low reset.
REQ-006 SHALL have ports: i_inst_vld_1, i_inst_vld_2 in 1 each, fetch-slot valids; i_pc_1, i_pc_2 in PC_W each, slot PCs.
REQ-007 SHALL have ports: o_pred_jmp out 1, predicted taken; o_pred_slot out 1, 0=slot1 1=slot2; o_pred_tgt out PC_W, target; o_ghr out GHR_W, GHR at lookup.
REQ-008 SHALL have commit ports: i_com_br in 1; i_com_pc in PC_W; i_com_ghr in GHR_W; i_com_jmpaddr in PC_W; i_com_jmpcond in 1, actual taken; i_com_mispred in 1.
REQ-009 SHALL have RAS ports: i_ras_push in 1; i_ras_push_addr in PC_W; i_ras_pop in 1; o_ras_top out PC_W; o_ras_empty out 1.

Function
REQ-010 SHALL index BTB with pc[2+:log2(BTB_ENT)], tag pc[PC_W-1:2+log2(BTB_ENT)], one valid bit per entry; hit = valid and tag match and slot valid.
REQ-011 SHALL index PHT with pc[2+:GHR_W] XOR current GHR, for both slots.
REQ-012 SHALL produce the lookup combinationally in the same cycle (0-cycle latency); slot taken = BTB hit and counter MSB=1.
REQ-013 SHALL give slot 1 priority: if slot 1 is predicted taken, o_pred_slot=0 and slot 2 is ignored; otherwise slot 2's result is used (o_pred_slot=1); o_pred_tgt is the target of the chosen slot, or 0 when not taken.
REQ-014 SHALL speculatively update the GHR each cycle: one shift-in (LSB) per BTB-hit slot up to and including the first predicted-taken slot, in slot order; at most 2 shifts per cycle.
REQ-015 SHALL, on i_com_br and i_com_mispred, set GHR <= {i_com_ghr[GHR_W-2:0], i_com_jmpcond}; this overrides any same-cycle speculative shift.
REQ-016 SHALL, on i_com_br, update the PHT counter at i_com_pc[2+:GHR_W] XOR i_com_ghr: saturating +1 if taken, -1 if not; it saturates at 3 and 0.
REQ-017 SHALL, on i_com_br and i_com_jmpcond, write the BTB entry (valid=1, tag, target=i_com_jmpaddr); not-taken commits leave the BTB unchanged.
REQ-018 SHALL return old data on a same-cycle read/write to the same index (no bypass); the update is visible the next cycle.

Reset
REQ-019 SHALL, on rst_n low (asynchronous), clear GHR to 0, set all PHT counters to 2'b01, clear all BTB valid bits, clear the RAS pointer and count; BTB tag/target arrays are not reset.
REQ-020 SHALL drive all outputs to 0 during reset, except o_ras_empty=1.

Configuration
REQ-021 SHALL, with BPRED_RAS_EN defined, implement a circular RAS: push writes i_ras_push_addr at top; full push overwrites the oldest entry; pop on empty is ignored; simultaneous push+pop replaces the top (count unchanged).
REQ-022 SHALL, without BPRED_RAS_EN, keep the RAS ports, ignore i_ras_push and i_ras_pop, tie o_ras_top to 0 and o_ras_empty to 1, and instantiate no RAS storage.

Structure
REQ-023 SHALL take counter encodings (SNT=0, WNT=1, WT=2, ST=3) and the PHT reset value from the shared constants header; all other widths are derived from the parameters.
REQ-024 SHALL place the 2-bit saturating-counter update in one sub-module, bpred_sat_ctr2.

Verification
REQ-025 After reset, lookup i_pc_1=0x100 -> o_pred_jmp=0, o_ghr=0, o_ras_empty=1.
REQ-026 Two commits i_com_br=1, i_com_pc=0x100, i_com_ghr=0, i_com_jmpcond=1, i_com_jmpaddr=0x200 -> counter goes 1->2->3; next lookup of 0x100 -> o_pred_jmp=1, o_pred_slot=0, o_pred_tgt=0x200.
REQ-027 Trained 0x104 taken and 0x100 not in BTB; slot1=0x100, slot2=0x104 -> o_pred_slot=1, GHR shifts by 1 bit.
REQ-028 GHR=0xA5 with i_com_mispred=1, i_com_ghr=0x3C, i_com_jmpcond=1, plus same-cycle fetch hit -> next GHR=0x79.
REQ-029 Counter at 3 with a taken commit -> stays 3; counter at 0 with a not-taken commit -> stays 0.
REQ-030 With BPRED_RAS_EN, RAS_DEPTH=4: push 0x10,0x20,0x30,0x40,0x50, then pop 4 times -> o_ras_top sequence 0x50,0x40,0x30,0x20, then o_ras_empty=1; a further pop leaves o_ras_empty=1.
